sigmoid_out_fifo: RTL and testbench
===================================

SIGMOID_OUT_FIFO -- requirements
Module: sigmoid_out_fifo

Interface
REQ-001 Parameter: DEPTH, default 8, FIFO entry count; SHALL be a power of two, at least 2.
REQ-002 Parameter: CW, default 4, count width; SHALL equal log2(DEPTH)+1.
REQ-003 Port: clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-004 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port: i_y, input, 16, sigmoid result sample from the upstream sigmoid pipeline.
REQ-006 Port: i_in_valid, input, 1, i_y is valid this cycle; the upstream stage cannot stall, so there is no input ready.
REQ-007 Port: o_y, output, 16, head-of-FIFO sample.
REQ-008 Port: o_out_valid, output, 1, o_y holds a valid entry.
REQ-009 Port: i_out_ready, input, 1, consumer accepts o_y this cycle.
REQ-010 Port: o_count, output, CW, number of stored entries, 0..DEPTH.
REQ-011 Port: o_overflow, output, 1, sticky flag: a sample was dropped.
REQ-012 Port: o_sum, output, 24, running sum of popped samples (see Configuration).
REQ-013 Port: number, output, 51, constant nonzero transistor estimate of this block, independent of reset and inputs.

Function
REQ-014 Push: occurs on a rising edge when i_in_valid=1 and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-015 Pop: occurs on a rising edge when o_out_valid=1 and i_out_ready=1.
REQ-016 Latency: a pushed sample SHALL become visible on o_y/o_out_valid exactly one cycle after its push edge; there is no same-cycle bypass when the FIFO is empty.
REQ-017 o_out_valid SHALL equal (o_count != 0), driven from registered state only.
REQ-018 o_y SHALL show the oldest stored entry when o_count>0 and 16'h0000 when the FIFO is empty.
REQ-019 Order: samples SHALL be delivered strictly FIFO, bit-exact, with no duplication.
REQ-020 Simultaneous push and pop SHALL leave o_count unchanged, including the full case (the push is accepted) and the count=1 case.
REQ-021 Push while full without a pop: the sample SHALL be dropped, o_overflow set to 1 from the next cycle, and stored contents left untouched.
REQ-022 o_overflow SHALL be sticky until reset.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH with no lost or repeated entries across the wrap.
REQ-024 i_out_ready=1 while the FIFO is empty SHALL have no effect.
REQ-025 i_y SHALL be ignored when i_in_valid=0; X on i_y while i_in_valid=0 SHALL NOT propagate into state.
REQ-026 Continuous streaming at one sample per cycle with i_out_ready held at 1 SHALL sustain full throughput, with o_out_valid held high continuously after the first output.

Reset
REQ-027 While rst_n=0, asynchronously: o_count=0, o_out_valid=0, o_y=0, o_overflow=0, o_sum=0, and both pointers=0.
REQ-028 Reset asserted mid-stream SHALL discard all stored entries; the first push after release SHALL be delivered as the first output.
REQ-029 Memory array contents need not be reset; they SHALL never be observable while o_count=0.

Configuration
REQ-030 With SIGMOID_FIFO_SUM_EN defined, o_sum SHALL add the popped o_y (zero-extended) on every pop, wrapping modulo 2^24, and update one cycle after the pop edge.
REQ-031 Without SIGMOID_FIFO_SUM_EN, o_sum SHALL be constant 0, the accumulator logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 After reset, push 16'h0001..16'h0008 on consecutive cycles with i_out_ready=0 -> o_count=8, o_overflow=0, o_y=16'h0001.
REQ-033 Full FIFO, push 16'hBEEF with i_out_ready=0 -> o_overflow=1 and o_count=8; then drain with i_out_ready=1 -> 16'h0001..16'h0008 in order, 16'hBEEF never appears.
REQ-034 Full FIFO, i_in_valid=1 (16'h1234) and i_out_ready=1 in the same cycle -> o_count stays 8, and 16'h1234 is output after 16'h0002..16'h0008.
REQ-035 256-sample stream at one per cycle with i_out_ready=1 -> the first o_out_valid one cycle after the first push, o_out_valid continuously high for 256 cycles, outputs equal to inputs, o_overflow=0.
REQ-036 Push 16'h8000 twice, pop both -> o_sum=24'h010000 with SIGMOID_FIFO_SUM_EN defined, 0 without it.
REQ-037 Assert rst_n=0 with 5 entries stored -> all outputs 0 immediately; after release, push 16'h00AA -> o_y=16'h00AA one cycle later.

Source files
------------

// File: rtl/sigmoid_out_fifo.sv
// Output FIFO behind the sigmoid pipeline: no input backpressure, sticky overflow on drop.
// Optional popped-sample accumulator on o_sum, enabled by defining SIGMOID_FIFO_SUM_EN.
module sigmoid_out_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   i_y,
  input  logic          i_in_valid,
  output logic [15:0]   o_y,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [CW-1:0] o_count,
  output logic          o_overflow,
  output logic [23:0]   o_sum,
  output logic [50:0]   number
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [50:0] NUMBER = 51'd4650;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full        = (count_q == CW'(DEPTH));
  assign o_out_valid = (count_q != '0);
  assign o_y         = o_out_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign o_count     = count_q;
  assign o_overflow  = overflow_q;
  assign number      = NUMBER;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = o_out_valid && i_out_ready;
  assign do_push = i_in_valid && (!full || do_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (i_in_valid && !do_push) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; o_y is gated off whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_y;
  end

`ifdef SIGMOID_FIFO_SUM_EN
  logic [23:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (do_pop) sum_d = sum_q + 24'(o_y);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign o_sum = sum_q;
`else
  assign o_sum = 24'h000000;
`endif

endmodule

// File: tb/tb_sigmoid_out_fifo.sv
// Self-checking bench for sigmoid_out_fifo: directed vector table, corner sequences, random vs queue model.
module tb_sigmoid_out_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   i_y;
  logic          i_in_valid;
  logic [15:0]   o_y;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [CW-1:0] o_count;
  logic          o_overflow;
  logic [23:0]   o_sum;
  logic [50:0]   number;

  sigmoid_out_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .i_y(i_y), .i_in_valid(i_in_valid),
    .o_y(o_y), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_count(o_count), .o_overflow(o_overflow), .o_sum(o_sum), .number(number)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] y;
    logic        r;
    int          ecount;
    logic [15:0] ey;
    logic        ev;
    logic        eo;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  int tests = 0;
  int fails = 0;

  // Reference model: plain queue plus flags.
  logic [15:0] mq [$];
  logic        movf;
  logic [23:0] msum;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    movf = 1'b0;
    msum = 24'h0;
  endtask

  task automatic model_step(input logic v, input logic [15:0] y, input logic r);
    bit pop, push;
    logic [15:0] head;
    pop  = (mq.size() > 0) && r;
    push = v && ((mq.size() < DEPTH) || pop);
    if (v && !push) movf = 1'b1;
    if (pop) begin
      head = mq.pop_front();
`ifdef SIGMOID_FIFO_SUM_EN
      msum = msum + {8'h00, head};
`endif
    end
    if (push) mq.push_back(y);
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".count"}, 64'(o_count), 64'(mq.size()));
    chk({tag, ".valid"}, 64'(o_out_valid), 64'(mq.size() != 0));
    chk({tag, ".y"}, 64'(o_y), (mq.size() != 0) ? 64'(mq[0]) : 64'h0);
    chk({tag, ".ovf"}, 64'(o_overflow), 64'(movf));
    chk({tag, ".sum"}, 64'(o_sum), 64'(msum));
  endtask

  // Drive at posedge+1, model the edge, then sample at next posedge+1.
  task automatic cycle(input logic v, input logic [15:0] y, input logic r);
    i_in_valid  = v;
    i_y         = y;
    i_out_ready = r;
    model_step(v, y, r);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_in_valid = 1'b0; i_out_ready = 1'b0; i_y = 16'h0;
    model_reset();
    #3;
    rst_n = 1'b1;
  endtask

  task automatic setv(input int k, input logic v, input logic [15:0] y, input logic r,
                      input int ec, input logic [15:0] ey, input logic ev, input logic eo);
    tbl[k].v = v; tbl[k].y = y; tbl[k].r = r;
    tbl[k].ecount = ec; tbl[k].ey = ey; tbl[k].ev = ev; tbl[k].eo = eo;
  endtask

  initial begin
    logic [15:0] s;
    int p_v, p_r;

    // Fill to full, overflow, full push+pop, drain, idle corner cases.
    for (int k = 0; k < 8; k++) setv(k, 1'b1, 16'(k + 1), 1'b0, k + 1, 16'h0001, 1'b1, 1'b0);
    setv(8, 1'b1, 16'hBEEF, 1'b0, 8, 16'h0001, 1'b1, 1'b1);
    setv(9, 1'b1, 16'h1234, 1'b1, 8, 16'h0002, 1'b1, 1'b1);
    for (int k = 10; k < 16; k++) setv(k, 1'b0, 16'h5555, 1'b1, 17 - k, 16'(k - 7), 1'b1, 1'b1);
    setv(16, 1'b0, 16'h5555, 1'b1, 1, 16'h1234, 1'b1, 1'b1);
    setv(17, 1'b0, 16'h5555, 1'b1, 0, 16'h0000, 1'b0, 1'b1);
    setv(18, 1'b0, 16'h6666, 1'b1, 0, 16'h0000, 1'b0, 1'b1);
    setv(19, 1'b0, 16'hxxxx, 1'b0, 0, 16'h0000, 1'b0, 1'b1);
    setv(20, 1'b1, 16'h00AA, 1'b0, 1, 16'h00AA, 1'b1, 1'b1);

    rst_n = 1'b0;
    i_in_valid = 1'b0; i_out_ready = 1'b0; i_y = 16'h0;
    model_reset();
    #2;
    chk("rst.count", 64'(o_count), 64'h0);
    chk("rst.valid", 64'(o_out_valid), 64'h0);
    chk("rst.y", 64'(o_y), 64'h0);
    chk("rst.ovf", 64'(o_overflow), 64'h0);
    chk("rst.sum", 64'(o_sum), 64'h0);
    chk("number.nonzero", 64'(number != 51'd0), 64'h1);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < NV; k++) begin
      cycle(tbl[k].v, tbl[k].y, tbl[k].r);
      chk($sformatf("vec%0d.count", k), 64'(o_count), 64'(tbl[k].ecount));
      chk($sformatf("vec%0d.y", k), 64'(o_y), 64'(tbl[k].ey));
      chk($sformatf("vec%0d.valid", k), 64'(o_out_valid), 64'(tbl[k].ev));
      chk($sformatf("vec%0d.ovf", k), 64'(o_overflow), 64'(tbl[k].eo));
    end

    // Reset with 5 entries stored clears everything immediately.
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1'b1, 16'(16'h0100 + k), 1'b0);
    chk("mid.count_pre", 64'(o_count), 64'd5);
    rst_n = 1'b0;
    #1;
    chk("mid.count", 64'(o_count), 64'h0);
    chk("mid.valid", 64'(o_out_valid), 64'h0);
    chk("mid.y", 64'(o_y), 64'h0);
    chk("mid.ovf", 64'(o_overflow), 64'h0);
    chk("mid.sum", 64'(o_sum), 64'h0);
    model_reset();
    #2;
    rst_n = 1'b1;
    cycle(1'b1, 16'h00AA, 1'b0);
    chk("mid.first_y", 64'(o_y), 64'h00AA);
    chk("mid.first_count", 64'(o_count), 64'd1);

    // Accumulator: two 0x8000 samples.
    do_reset();
    cycle(1'b1, 16'h8000, 1'b0);
    cycle(1'b1, 16'h8000, 1'b0);
    cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
`ifdef SIGMOID_FIFO_SUM_EN
    chk("sum.8000x2", 64'(o_sum), 64'h010000);
`else
    chk("sum.8000x2", 64'(o_sum), 64'h0);
`endif
    model_check("sum");

    // Full-throughput stream, 256 samples with ready held high.
    do_reset();
    cycle(1'b0, 16'h0, 1'b1);
    chk("stream.idle_valid", 64'(o_out_valid), 64'h0);
    for (int k = 0; k < 256; k++) begin
      s = 16'($urandom);
      cycle(1'b1, s, 1'b1);
      chk("stream.valid", 64'(o_out_valid), 64'h1);
      chk("stream.y", 64'(o_y), 64'(s));
    end
    cycle(1'b0, 16'h0, 1'b1);
    chk("stream.ovf", 64'(o_overflow), 64'h0);
    model_check("stream");

    // Random traffic in phases of different fill pressure.
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      p_v = (ph == 0) ? 90 : (ph == 1) ? 30 : (ph == 2) ? 60 : 75;
      p_r = (ph == 0) ? 40 : (ph == 1) ? 80 : (ph == 2) ? 60 : 100;
      for (int k = 0; k < 600; k++) begin
        logic v, r;
        v = ($urandom_range(0, 99) < p_v);
        r = ($urandom_range(0, 99) < p_r);
        cycle(v, v ? 16'($urandom) : 16'hxxxx, r);
        model_check($sformatf("rand%0d", ph));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
